csel_subtractor: RTL

CSEL_SUBTRACTOR -- requirements
Module: csel_subtractor

---
 rtl/csel_subtractor_if.sv | 37 +++
 rtl/csel_subtractor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/csel_subtractor_if.sv
// Operand/result handshake bundle for csel_subtractor.
// Carries the ovf result bit only when SUB_OVF_EN is defined.
interface csel_subtractor_if #(
    parameter int K = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] d;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, d, bout
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, d, bout
    );
`endif
endinterface

// File: rtl/csel_subtractor.sv
// Two-stage carry-select subtractor d = a + ~b + 1 with valid/ready flow control.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module csel_subtractor #(
    parameter int K = 64
) (
    input  logic               clk,
    input  logic               rst,
    csel_subtractor_if.slave   bus
);
    localparam int H = K / 2;

`ifdef SUB_OVF_EN
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) & (d_msb != a_msb);
    endfunction
`endif

    logic [H:0]   lo_sum_s;
    logic [H:0]   hi0_sum_s;
    logic [H:0]   hi1_sum_s;
    logic         s2_load_s;
    logic         s1_load_s;
    logic         in_ready_s;
    logic [H-1:0] hi_sel_s;
    logic         carry_sel_s;

    logic         s1_valid_r;
    logic [H-1:0] lo_r;
    logic         c_lo_r;
    logic [H-1:0] hi0_r;
    logic         c0_r;
    logic [H-1:0] hi1_r;
    logic         c1_r;
    logic         out_valid_r;
    logic [K-1:0] d_r;
    logic         bout_r;
`ifdef SUB_OVF_EN
    logic         a_msb_r;
    logic         b_msb_r;
    logic         ovf_r;
`endif

    // Low half with the +1 injected, and both upper-half candidates (carry-in 0 and 1).
    always_comb begin
        lo_sum_s  = {1'b0, bus.a[H-1:0]} + {1'b0, ~bus.b[H-1:0]} + {{H{1'b0}}, 1'b1};
        hi0_sum_s = {1'b0, bus.a[K-1:H]} + {1'b0, ~bus.b[K-1:H]};
        hi1_sum_s = {1'b0, bus.a[K-1:H]} + {1'b0, ~bus.b[K-1:H]} + {{H{1'b0}}, 1'b1};
    end

    // Pipeline advance: stage 2 takes stage 1 whenever the output slot is free or draining.
    always_comb begin
        s2_load_s  = s1_valid_r & (~out_valid_r | bus.out_ready);
        in_ready_s = ~s1_valid_r | s2_load_s;
        s1_load_s  = bus.in_valid & in_ready_s;
    end

    // Carry select: the registered low-half carry picks the upper candidate.
    always_comb begin
        if (c_lo_r) begin
            hi_sel_s    = hi1_r;
            carry_sel_s = c1_r;
        end else begin
            hi_sel_s    = hi0_r;
            carry_sel_s = c0_r;
        end
    end

    // Occupancy flags for both stages; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= 1'b1;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s2_load_s) begin
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Stage 1 data: low half result plus both upper-half candidates with carries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_r    <= {H{1'b0}};
            c_lo_r  <= 1'b0;
            hi0_r   <= {H{1'b0}};
            c0_r    <= 1'b0;
            hi1_r   <= {H{1'b0}};
            c1_r    <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
`endif
        end else if (s1_load_s) begin
            lo_r    <= lo_sum_s[H-1:0];
            c_lo_r  <= lo_sum_s[H];
            hi0_r   <= hi0_sum_s[H-1:0];
            c0_r    <= hi0_sum_s[H];
            hi1_r   <= hi1_sum_s[H-1:0];
            c1_r    <= hi1_sum_s[H];
`ifdef SUB_OVF_EN
            a_msb_r <= bus.a[K-1];
            b_msb_r <= bus.b[K-1];
`endif
        end
    end

    // Stage 2 result registers; borrow is the inverted final carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r    <= {K{1'b0}};
            bout_r <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else if (s2_load_s) begin
            d_r    <= {hi_sel_s, lo_r};
            bout_r <= ~carry_sel_s;
`ifdef SUB_OVF_EN
            ovf_r  <= ovf_calc(a_msb_r, b_msb_r, hi_sel_s[H-1]);
`endif
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.d         = d_r;
    assign bus.bout      = bout_r;
`ifdef SUB_OVF_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule
